// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//
// Shares the single-port data_memory between the core's EX/MEM-stage access
// path and an external DMA/debug requester (program loader, UART bridge).
// The core owns the port by default. A DMA request is granted in any cycle
// the core leaves the port free, or, once it has been blocked STARVE_LIMIT
// cycles in a row, by stalling the core for one cycle.
//
// Parameters
//   XLEN          data and address width
//   STARVE_LIMIT  blocked DMA cycles before the core is stalled (1..255)
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   core_*                core access (address, store data, wren, rden,
//                         mode, load extension)
//   core_stall            core must hold its access and re-present it
//   dma_req/we/address/wdata/mem_mode/mem_unsigned
//                         DMA request, fields stable until granted
//   dma_gnt               request accepted this cycle (commit cycle)
//   dma_rdata/dma_rvalid  read response, one cycle after a read grant
//   mem_*                 to data_memory; mem_q is its read data
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no DMA request has been blocked yet
// WAIT   | DMA request blocked by core traffic, cnt counts blocked cycles
// FORCE  | starvation limit reached, DMA wins and the core is stalled

module data_memory_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset,

    input  logic [XLEN-1:0] core_address,
    input  logic [XLEN-1:0] core_data,
    input  logic            core_wren,
    input  logic            core_rden,
    input  logic [1:0]      core_mem_mode,
    input  logic            core_mem_unsigned,
    output logic            core_stall,

    input  logic            dma_req,
    input  logic            dma_we,
    input  logic [XLEN-1:0] dma_address,
    input  logic [XLEN-1:0] dma_wdata,
    input  logic [1:0]      dma_mem_mode,
    input  logic            dma_mem_unsigned,
    output logic            dma_gnt,
    output logic [XLEN-1:0] dma_rdata,
    output logic            dma_rvalid,

    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_data,
    output logic            mem_wren,
    output logic [1:0]      mem_mode,
    output logic            mem_unsigned,
    input  logic [XLEN-1:0] mem_q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic       core_access;
    logic       grant;
    logic       stall;
    logic       rd_pend;
    logic       unsigned_q;

    assign core_access = core_wren | core_rden;

    // Saturating increment so cnt never wraps past the limit.
    assign cnt_inc = (cnt >= LIMIT) ? LIMIT : cnt + 8'd1;

    // Grant is decided in the same cycle the request is seen. It is gated by
    // reset so nothing is granted while the block is held in reset.
    always_comb begin
        grant = 1'b0;
        stall = 1'b0;
        if (reset) begin
            unique case (state)
                ST_IDLE, ST_WAIT: begin
                    grant = dma_req & ~core_access;
                end
                ST_FORCE: begin
                    grant = dma_req;
                    stall = dma_req & core_access;
                end
                default: begin
                    grant = 1'b0;
                    stall = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (dma_req && core_access) begin
                        cnt   <= 8'd1;
                        state <= (LIMIT == 8'd1) ? ST_FORCE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A free port grants the request; a dropped request is a
                    // protocol violation and simply abandons the wait.
                    if (!dma_req || !core_access) begin
                        cnt   <= 8'd0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == LIMIT) begin
                            state <= ST_FORCE;
                        end
                    end
                end
                ST_FORCE: begin
                    // Always back to IDLE so the core gets the next cycle.
                    cnt   <= 8'd0;
                    state <= ST_IDLE;
                end
                default: begin
                    cnt   <= 8'd0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read return: data_memory answers one cycle after the address, and its
    // output-stage extension select must follow the DMA's request then.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_pend    <= 1'b0;
            unsigned_q <= 1'b0;
        end else begin
            rd_pend    <= grant & ~dma_we;
            unsigned_q <= dma_mem_unsigned;
        end
    end

    assign dma_gnt    = grant;
    assign core_stall = stall;

    assign mem_address  = grant ? dma_address  : core_address;
    assign mem_data     = grant ? dma_wdata    : core_data;
    assign mem_wren     = grant ? dma_we       : core_wren;
    assign mem_mode     = grant ? dma_mem_mode : core_mem_mode;
    assign mem_unsigned = rd_pend ? unsigned_q : core_mem_unsigned;

    assign dma_rvalid = rd_pend;
    assign dma_rdata  = mem_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic            clock;
    logic            reset;
    logic [XLEN-1:0] core_address;
    logic [XLEN-1:0] core_data;
    logic            core_wren;
    logic            core_rden;
    logic [1:0]      core_mem_mode;
    logic            core_mem_unsigned;
    logic            core_stall;
    logic            dma_req;
    logic            dma_we;
    logic [XLEN-1:0] dma_address;
    logic [XLEN-1:0] dma_wdata;
    logic [1:0]      dma_mem_mode;
    logic            dma_mem_unsigned;
    logic            dma_gnt;
    logic [XLEN-1:0] dma_rdata;
    logic            dma_rvalid;
    logic [XLEN-1:0] mem_address;
    logic [XLEN-1:0] mem_data;
    logic            mem_wren;
    logic [1:0]      mem_mode;
    logic            mem_unsigned;
    logic [XLEN-1:0] mem_q;

    int n_checks = 0;
    int n_fail   = 0;

    data_memory_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clock             (clock),
        .reset             (reset),
        .core_address      (core_address),
        .core_data         (core_data),
        .core_wren         (core_wren),
        .core_rden         (core_rden),
        .core_mem_mode     (core_mem_mode),
        .core_mem_unsigned (core_mem_unsigned),
        .core_stall        (core_stall),
        .dma_req           (dma_req),
        .dma_we            (dma_we),
        .dma_address       (dma_address),
        .dma_wdata         (dma_wdata),
        .dma_mem_mode      (dma_mem_mode),
        .dma_mem_unsigned  (dma_mem_unsigned),
        .dma_gnt           (dma_gnt),
        .dma_rdata         (dma_rdata),
        .dma_rvalid        (dma_rvalid),
        .mem_address       (mem_address),
        .mem_data          (mem_data),
        .mem_wren          (mem_wren),
        .mem_mode          (mem_mode),
        .mem_unsigned      (mem_unsigned),
        .mem_q             (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte-lane helpers shared by the memory model and the reference.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] lane, input logic [1:0] mode);
        logic [31:0] r;
        r = old;
        case (mode)
            2'd0:    r[int'(lane)*8 +: 8]     = d[7:0];
            2'd1:    r[int'(lane[1])*16 +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [1:0] mode, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (mode)
            2'd0: begin
                b = w[int'(lane)*8 +: 8];
                r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            end
            2'd1: begin
                h = w[int'(lane[1])*16 +: 16];
                r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            end
            default: r = w;
        endcase
        return r;
    endfunction

    // Behavioural synchronous data_memory driven by the arbiter outputs.
    logic [31:0] env_mem [64];
    logic [7:0]  rd_addr;
    logic [1:0]  rd_mode;

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= 32'd0;
        end else if (mem_wren) begin
            env_mem[mem_address[7:2]] <= merge(env_mem[mem_address[7:2]], mem_data,
                                               mem_address[1:0], mem_mode);
        end
        rd_addr <= mem_address[7:0];
        rd_mode <= mem_mode;
    end

    assign mem_q = extract(env_mem[rd_addr[7:2]], rd_addr[1:0], rd_mode, mem_unsigned);

    // Reference model: who owns the port follows from how many consecutive
    // cycles the pending DMA request has been refused.
    logic [31:0] ref_mem [64];
    int          blocked;
    logic        m_rvalid;
    logic        m_runs;
    logic [31:0] m_rdata;
    logic        m_gnt;
    logic        m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        blocked  = 0;
        m_rvalid = 1'b0;
        m_runs   = 1'b0;
        m_rdata  = 32'd0;
        m_gnt    = 1'b0;
        m_stall  = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    endtask

    // One clock cycle: inputs are already driven; compare at the falling
    // edge, advance the model, then step past the next rising edge.
    task automatic cycle();
        logic ca, forced, e_gnt, e_stall;
        @(negedge clock);
        ca      = core_wren | core_rden;
        forced  = (blocked >= LIMIT);
        e_gnt   = forced ? dma_req : (dma_req & ~ca);
        e_stall = forced & dma_req & ca;
        check("dma_gnt",      32'(dma_gnt),      32'(e_gnt));
        check("core_stall",   32'(core_stall),   32'(e_stall));
        check("mem_wren",     32'(mem_wren),     32'(e_gnt ? dma_we : core_wren));
        check("mem_address",  mem_address,       e_gnt ? dma_address : core_address);
        check("mem_data",     mem_data,          e_gnt ? dma_wdata : core_data);
        check("mem_mode",     32'(mem_mode),     32'(e_gnt ? dma_mem_mode : core_mem_mode));
        check("dma_rvalid",   32'(dma_rvalid),   32'(m_rvalid));
        check("mem_unsigned", 32'(mem_unsigned), 32'(m_rvalid ? m_runs : core_mem_unsigned));
        if (m_rvalid) check("dma_rdata", dma_rdata, m_rdata);

        if (dma_req && !e_gnt) blocked++;
        else blocked = 0;
        if (e_gnt && dma_we)
            ref_mem[dma_address[7:2]] = merge(ref_mem[dma_address[7:2]], dma_wdata,
                                              dma_address[1:0], dma_mem_mode);
        else if (!e_gnt && core_wren)
            ref_mem[core_address[7:2]] = merge(ref_mem[core_address[7:2]], core_data,
                                               core_address[1:0], core_mem_mode);
        m_rvalid = e_gnt & ~dma_we;
        m_runs   = dma_mem_unsigned;
        if (e_gnt && !dma_we)
            m_rdata = extract(ref_mem[dma_address[7:2]], dma_address[1:0],
                              dma_mem_mode, dma_mem_unsigned);
        m_gnt   = e_gnt;
        m_stall = e_stall;
        @(posedge clock);
        #1;
    endtask

    task automatic core_op(input logic wr, input logic rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] mode, input logic uns);
        core_wren         = wr;
        core_rden         = rd;
        core_address      = a;
        core_data         = d;
        core_mem_mode     = mode;
        core_mem_unsigned = uns;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] mode, input logic uns);
        dma_req          = req;
        dma_we           = we;
        dma_address      = a;
        dma_wdata        = d;
        dma_mem_mode     = mode;
        dma_mem_unsigned = uns;
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] mode);
        logic [31:0] a;
        a = 32'($urandom_range(0, 255));
        if (mode == 2'd1) a[0] = 1'b0;
        if (mode == 2'd2) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        logic       pending;
        logic [1:0] md;
        int         sel;

        model_reset();
        reset = 1'b0;
        core_op(1'b1, 1'b0, 32'h88, 32'h5555_AAAA, 2'd2, 1'b0);
        set_dma(1'b1, 1'b1, 32'h40, 32'h1111_2222, 2'd2, 1'b1);

        // Reset values: nothing granted even with an idle-port request pending.
        repeat (2) @(posedge clock);
        #1;
        check("rst_gnt",     32'(dma_gnt),     32'd0);
        check("rst_stall",   32'(core_stall),  32'd0);
        check("rst_rvalid",  32'(dma_rvalid),  32'd0);
        check("rst_wren",    32'(mem_wren),    32'd1);
        check("rst_address", mem_address,      32'h88);
        check("rst_uns",     32'(mem_unsigned), 32'd0);
        core_op(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // 1: idle-port DMA write, then a core load sees it.
        set_dma(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 2'd2, 1'b0);
        #2;
        check("t1_gnt",     32'(dma_gnt),  32'd1);
        check("t1_wren",    32'(mem_wren), 32'd1);
        check("t1_address", mem_address,   32'h40);
        cycle();
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        core_op(1'b0, 1'b1, 32'h40, 32'h0, 2'd2, 1'b0);
        cycle();
        check("t1_core_load", mem_q, 32'hDEAD_BEEF);
        core_op(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);

        // 2: DMA read, response exactly one cycle later for one cycle.
        set_dma(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
        #2;
        check("t2_gnt", 32'(dma_gnt), 32'd1);
        cycle();
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        #2;
        check("t2_rvalid", 32'(dma_rvalid), 32'd1);
        check("t2_rdata",  dma_rdata,       32'hDEAD_BEEF);
        cycle();
        #2;
        check("t2_rvalid_drop", 32'(dma_rvalid), 32'd0);
        cycle();

        // 3: starvation under continuous core loads.
        core_op(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0);
        set_dma(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #2;
            check("t3_gnt",   32'(dma_gnt),    32'(i == 4));
            check("t3_stall", 32'(core_stall), 32'(i == 4));
            cycle();
        end
        set_dma(1'b1, 1'b0, 32'h44, 32'h0, 2'd2, 1'b0);
        for (int i = 5; i < 10; i++) begin
            #2;
            check("t3_gnt2",   32'(dma_gnt),    32'(i == 9));
            check("t3_stall2", 32'(core_stall), 32'(i == 9));
            cycle();
        end
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        core_op(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        cycle();

        // 4: core gap after two blocked cycles; the wait count restarts.
        core_op(1'b1, 1'b0, 32'h20, 32'h0BAD_F00D, 2'd2, 1'b0);
        set_dma(1'b1, 1'b1, 32'h60, 32'h1234_5678, 2'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #2;
            check("t4_blocked", 32'(dma_gnt), 32'd0);
            cycle();
        end
        core_op(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        #2;
        check("t4_gap_gnt",   32'(dma_gnt),    32'd1);
        check("t4_gap_stall", 32'(core_stall), 32'd0);
        cycle();
        core_op(1'b0, 1'b1, 32'h60, 32'h0, 2'd2, 1'b0);
        set_dma(1'b1, 1'b1, 32'h64, 32'hCAFE_F00D, 2'd2, 1'b0);
        for (int i = 3; i < 8; i++) begin
            #2;
            check("t4_regnt", 32'(dma_gnt), 32'(i == 7));
            cycle();
        end
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        core_op(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);

        // 5: DMA lbu of 0x80 while the core sign-extends its own loads.
        set_dma(1'b1, 1'b1, 32'h51, 32'h0000_0080, 2'd0, 1'b0);
        cycle();
        set_dma(1'b1, 1'b0, 32'h51, 32'h0, 2'd0, 1'b1);
        cycle();
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        core_op(1'b0, 1'b1, 32'h51, 32'h0, 2'd0, 1'b0);
        #2;
        check("t5_rvalid", 32'(dma_rvalid),   32'd1);
        check("t5_rdata",  dma_rdata,         32'h0000_0080);
        check("t5_uns",    32'(mem_unsigned), 32'd1);
        cycle();
        core_op(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        #2;
        check("t5_core_uns", 32'(mem_unsigned), 32'd0);
        check("t5_core_lb",  mem_q,             32'hFFFF_FF80);
        cycle();

        // Randomized traffic against the reference model.
        pending = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!m_stall) begin
                sel = int'($urandom_range(0, 3));
                md  = 2'($urandom_range(0, 2));
                core_op(sel == 1, sel >= 2, rand_addr(md), $urandom, md, 1'($urandom_range(0, 1)));
            end
            if (!pending && ($urandom_range(0, 3) == 0)) begin
                md = 2'($urandom_range(0, 2));
                set_dma(1'b1, 1'($urandom_range(0, 1)), rand_addr(md), $urandom, md,
                        1'($urandom_range(0, 1)));
                pending = 1'b1;
            end else if (pending && ($urandom_range(0, 23) == 0)) begin
                dma_req = 1'b0;
                pending = 1'b0;
            end else if (!pending) begin
                dma_req = 1'b0;
            end
            cycle();
            if (m_gnt) begin
                pending = 1'b0;
                dma_req = 1'b0;
            end
        end
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        core_op(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        cycle();

        // 6: reset in the cycle after a read grant drops the response.
        set_dma(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b1);
        cycle();
        core_op(1'b0, 1'b0, 32'h88, 32'h0, 2'd2, 1'b0);
        reset = 1'b0;
        #1;
        check("t6_rvalid",  32'(dma_rvalid),   32'd0);
        check("t6_gnt",     32'(dma_gnt),      32'd0);
        check("t6_stall",   32'(core_stall),   32'd0);
        check("t6_address", mem_address,       32'h88);
        check("t6_uns",     32'(mem_unsigned), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        @(posedge clock);
        #1;
        set_dma(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
        cycle();
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Shares the single-port `data_memory` between the core's memory-access path and an external DMA/debug requester, such as a program loader or UART bridge. The core normally owns the port. DMA requests are granted in cycles where the core makes no access, or by stalling the core once a DMA request has waited `STARVE_LIMIT` blocked cycles. The block sits between the core's EX/MEM-stage memory signals and the `data_memory` instance, and its `core_stall` is ORed into the core's hazard stall.

## Interface
- `XLEN`, 32, data and address width.
- `STARVE_LIMIT`, 4, number of blocked DMA cycles before the core is forcibly stalled; legal range 1–255.

- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `core_address` input XLEN: core access address (EX-stage ALU result).
- `core_data` input XLEN: core store data.
- `core_wren` input 1: core store this cycle.
- `core_rden` input 1: core load this cycle.
- `core_mem_mode` input 2: byte/half/word mode.
- `core_mem_unsigned` input 1: core load extension, MEM-stage timing.
- `core_stall` output 1: core must hold its access and re-present it next cycle.
- `dma_req` input 1: DMA request; fields must remain stable until granted.
- `dma_we` input 1: 1 = write, 0 = read.
- `dma_address` input XLEN: DMA address.
- `dma_wdata` input XLEN: DMA write data.
- `dma_mem_mode` input 2: DMA access mode.
- `dma_mem_unsigned` input 1: DMA load extension.
- `dma_gnt` output 1: the request is accepted this cycle.
- `dma_rdata` output XLEN: DMA read data.
- `dma_rvalid` output 1: `dma_rdata` is valid.
- `mem_address` output XLEN: address to `data_memory`.
- `mem_data` output XLEN: write data to `data_memory`.
- `mem_wren` output 1: write enable to `data_memory`.
- `mem_mode` output 2: mode to `data_memory`.
- `mem_unsigned` output 1: extension select to `data_memory`, output stage.
- `mem_q` input XLEN: `data_memory` read data.

## Operation
- `core_access` = `core_wren | core_rden`.
- **FSM states:** IDLE, WAIT, FORCE. A wait counter `cnt` is 8 bits wide and saturates at `STARVE_LIMIT`.
- **IDLE**
  - `dma_req & !core_access`: grant, stay in IDLE.
  - `dma_req & core_access`: no grant; `cnt <= 1`; go to WAIT, or go to FORCE if `STARVE_LIMIT == 1`.
- **WAIT**
  - `dma_req & !core_access`: grant; `cnt <= 0`; go to IDLE.
  - `dma_req & core_access`: `cnt <= cnt+1`; go to FORCE when `cnt+1 == STARVE_LIMIT`.
  - `!dma_req` (protocol violation): go to IDLE, `cnt <= 0`.
- **FORCE**
  - Grant unconditionally; `core_stall = core_access`; `cnt <= 0`; go to IDLE.
  - `!dma_req` in FORCE: no grant, no stall; go to IDLE.
- **Grant behaviour** (combinational, same cycle):
  - `dma_gnt = 1`.
  - `mem_*` driven from the `dma_*` fields.
  - `mem_wren = dma_we`.
- **No grant:** `mem_*` driven from the `core_*` fields and `mem_wren = core_wren`; `core_stall = 0`.
- **Fairness:** after a forced grant the FSM returns to IDLE, so the core receives at least one access per `STARVE_LIMIT+1` contended cycles.
- **Read return registers:** `rd_pend <= dma_gnt & !dma_we` and `unsigned_q <= dma_mem_unsigned`.
  - `mem_unsigned = rd_pend ? unsigned_q : core_mem_unsigned`.
  - `dma_rvalid = rd_pend`.
  - `dma_rdata = mem_q`.
- DMA writes produce no response; the grant cycle is the commit cycle.

## Timing
- **Reset** (asynchronous, while `reset` == 0):
  - State IDLE, `cnt = 0`, `rd_pend = 0`, `unsigned_q = 0`.
  - `dma_gnt = 0`, `dma_rvalid = 0`, `core_stall = 0`.
  - `mem_*` follow `core_*`, with `mem_wren = core_wren`.
- **Grant latency:** 0 cycles when the core is idle; exactly `STARVE_LIMIT` cycles under continuous core traffic.
- **Read latency:** `dma_rvalid` is high exactly 1 cycle after the read grant, for 1 cycle. Back-to-back grants give back-to-back `dma_rvalid`.
- `core_stall` is high only in a FORCE grant cycle in which the core was accessing, and for at most 1 consecutive cycle.
- A reset asserted mid-read drops the pending `dma_rvalid`.

## Test plan
1. **Idle grant:** core idle, `dma_req=1`, `dma_we=1`, addr `0x40`, data `0xDEADBEEF` → `dma_gnt=1` in the same cycle, `mem_wren=1`, `mem_address=0x40`. A later core load of `0x40` returns `0xDEADBEEF`.
2. **DMA read:** DMA read of `0x40` with core idle → `dma_rvalid=1` one cycle later, `dma_rdata=0xDEADBEEF`.
3. **Starvation:** `STARVE_LIMIT=4`, core loads every cycle, `dma_req` raised at cycle 0.
   - Cycles 0–3: `dma_gnt=0`, `core_stall=0`.
   - Cycle 4: `dma_gnt=1`, `core_stall=1`.
   - Cycle 5: core access proceeds; a still-pending second request is granted at cycle 9.
4. **Core gap:** core accessing, DMA waiting 2 cycles, core idle at cycle 2 → grant at cycle 2, no stall, FSM returns to IDLE, `cnt=0`.
5. **Unsigned routing:** DMA `lbu` of byte `0x80` while the core's `core_mem_unsigned=0` → `dma_rdata=0x00000080`; core loads in the following cycles still sign-extend.
6. **Reset mid-read:** assert `reset=0` in the cycle after a DMA read grant → `dma_rvalid=0` immediately; all outputs at their reset values.
